// File: rtl/ram_responder.sv
`timescale 1ns/1ps
// Block-RAM slave for the SDRAM controller az_*/za_* request interface: zero-fill on reset,
// then one request per cycle with fixed read latency. Define RAM_RESP_REFRESH_STALL_EN for refresh stalls.
module ram_responder #(
  parameter int MEM_AW         = 12,
  parameter int READ_LATENCY   = 2,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [21:0] az_addr,
  input  logic [1:0]  az_be_n,
  input  logic        az_cs,
  input  logic [15:0] az_data,
  input  logic        az_rd_n,
  input  logic        az_wr_n,
  output logic [15:0] za_data,
  output logic        za_valid,
  output logic        za_waitrequest
);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_STALL} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [MEM_AW-1:0]       r_sweep;
  logic                    r_waitreq;
  logic [15:0]             r_mem [2**MEM_AW];
  logic [15:0]             r_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_vld;

  logic [MEM_AW-1:0] w_addr;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_unused_addr;

  assign w_addr        = az_addr[MEM_AW-1:0];
  assign w_unused_addr = &{1'b0, az_addr[21:MEM_AW]};
  // A simultaneous read+write is treated as a write only.
  assign w_wr_acc = az_cs & ~az_wr_n & ~r_waitreq;
  assign w_rd_acc = az_cs & ~az_rd_n & az_wr_n & ~r_waitreq;

`ifdef RAM_RESP_REFRESH_STALL_EN
  localparam int RCW = $clog2(REFRESH_PERIOD);
  localparam int SCW = $clog2(REFRESH_CYCLES + 1);
  logic [RCW-1:0] r_ref_cnt;
  logic [SCW-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ref_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state == S_RUN)
        r_ref_cnt <= (w_next == S_STALL) ? '0 : r_ref_cnt + 1'b1;
      else if (r_state == S_CLEAR)
        r_ref_cnt <= '0;
      r_stall_cnt <= (r_state == S_STALL) ? r_stall_cnt + 1'b1 : '0;
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (r_sweep == {MEM_AW{1'b1}}) w_next = S_RUN;
`ifdef RAM_RESP_REFRESH_STALL_EN
      S_RUN:   if (r_ref_cnt == RCW'(REFRESH_PERIOD - 1)) w_next = S_STALL;
      S_STALL: if (r_stall_cnt == SCW'(REFRESH_CYCLES - 1)) w_next = S_RUN;
`else
      S_RUN:   w_next = S_RUN;
      S_STALL: w_next = S_RUN;
`endif
      default: w_next = S_CLEAR;
    endcase
  end

  // Waitrequest is registered from the next state so it never depends on az_*.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_CLEAR;
      r_sweep   <= '0;
      r_waitreq <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_waitreq <= (w_next != S_RUN);
      if (r_state == S_CLEAR) r_sweep <= r_sweep + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_sweep] <= '0;
    end else if (w_wr_acc) begin
      if (!az_be_n[0]) r_mem[w_addr][7:0]  <= az_data[7:0];
      if (!az_be_n[1]) r_mem[w_addr][15:8] <= az_data[15:8];
    end
  end

  // Read pipeline: stage 0 captures the RAM word, later stages shift only on valid so za_data holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) r_dat[k] <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) r_dat[0] <= r_mem[w_addr];
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign za_valid       = r_vld[READ_LATENCY-1];
  assign za_data        = r_dat[READ_LATENCY-1];
  assign za_waitrequest = r_waitreq;

endmodule

// File: tb/tb_ram_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for ram_responder: reads push expected data/cycle, a negedge monitor pops and compares.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [21:0] az_addr = '0;
  logic [1:0]  az_be_n = 2'b11;
  logic        az_cs = 1'b0;
  logic [15:0] az_data = '0;
  logic        az_rd_n = 1'b1;
  logic        az_wr_n = 1'b1;
  logic [15:0] za_data;
  logic        za_valid;
  logic        za_waitrequest;

  ram_responder dut (
    .clk(clk), .reset_n(reset_n), .az_addr(az_addr), .az_be_n(az_be_n), .az_cs(az_cs),
    .az_data(az_data), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n), .za_data(za_data),
    .za_valid(za_valid), .za_waitrequest(za_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [15:0] q_dat[$];
  int          q_cyc[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] ed;
    int          ec;
    if (za_valid === 1'b1) begin
      if (q_dat.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %h at cycle %0d expected no response", za_data, cyc);
      end else begin
        ed = q_dat.pop_front();
        ec = q_cyc.pop_front();
        chk("rd_data", 32'(za_data), 32'(ed));
        chk("rd_cycle", cyc, ec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic rd_n, input logic wr_n,
                       input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
    az_cs = cs; az_rd_n = rd_n; az_wr_n = wr_n; az_addr = a; az_data = d; az_be_n = be;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b1, 1'b1, 22'h0, 16'h0, 2'b11);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b1, 1'b1, 1'b0, a, d, be);
    tick();
  endtask

  task automatic rd(input logic [21:0] a, input logic [15:0] e);
    drive(1'b1, 1'b0, 1'b1, a, 16'h0, 2'b00);
    q_dat.push_back(e);
    q_cyc.push_back(cyc + 2);
    tick();
  endtask

  task automatic wait_clear();
    int n = 0;
    @(negedge clk);
    while (za_waitrequest && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("clear_len", n, 4096);
    chk("wait_low", 32'(za_waitrequest), 0);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    idle(1);
    while (q_dat.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain", q_dat.size(), 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_waitreq", 32'(za_waitrequest), 1);
    chk("rst_valid", 32'(za_valid), 0);
    chk("rst_data", 32'(za_data), 0);
    tick();
    reset_n = 1'b1;
    wait_clear();

    rd(22'h3FF, 16'h0000);
    idle(3);

    wr(22'h010, 16'hBEEF, 2'b00);
    rd(22'h010, 16'hBEEF);
    rd(22'h1010, 16'hBEEF);
    idle(1);

    wr(22'h020, 16'hFFFF, 2'b00);
    wr(22'h020, 16'h1234, 2'b01);
    rd(22'h020, 16'h12FF);
    wr(22'h020, 16'h0000, 2'b11);
    rd(22'h020, 16'h12FF);
    drive(1'b0, 1'b1, 1'b0, 22'h020, 16'h0000, 2'b00);
    tick();
    rd(22'h020, 16'h12FF);

    drive(1'b1, 1'b0, 1'b0, 22'h030, 16'h5555, 2'b00);
    tick();
    rd(22'h030, 16'h5555);
    wr(22'h3FF040, 16'h7777, 2'b00);
    rd(22'h040, 16'h7777);
    idle(1);

    for (int i = 0; i < 8; i++) wr(22'(i), 16'hA000 + 16'(i), 2'b00);
    for (int i = 0; i < 8; i++) rd(22'(i), 16'hA000 + 16'(i));
    idle(4);
    @(negedge clk);
    chk("hold_valid", 32'(za_valid), 0);
    chk("hold_data", 32'(za_data), 32'h0000A007);
    tick();
    drain();

    drive(1'b1, 1'b0, 1'b1, 22'h005, 16'h0, 2'b00);
    tick();
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 22'h0, 16'h0, 2'b11);
    #1;
    chk("midrst_waitreq", 32'(za_waitrequest), 1);
    chk("midrst_valid", 32'(za_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(za_valid), 0);
    end
    tick();
    reset_n = 1'b1;
    wait_clear();

    rd(22'h010, 16'h0000);
    rd(22'h005, 16'h0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

On-chip block-RAM responder that implements the slave end of the 16-bit SDRAM controller's `az_*`/`za_*` request interface (addr, be_n, cs, data, rd_n, wr_n / data, valid, waitrequest). It replaces the SDRAM controller in the recorder datapath so the play/record engine can run unchanged against internal memory, with the same pipelined-read, waitrequest-stalled behaviour. On reset it zero-fills its memory, then services one request per cycle with a fixed read latency.

## Interface
- `MEM_AW`, 12: internal word-address width; depth = 2^MEM_AW 16-bit words.
- `READ_LATENCY`, 2: cycles from read-accept cycle to `za_valid` cycle; legal range 1..4.
- `REFRESH_PERIOD`, 780: cycles between refresh stalls (macro-enabled only); must be greater than `REFRESH_CYCLES`.
- `REFRESH_CYCLES`, 4: length of each refresh stall in cycles (macro-enabled only).

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `az_addr` in 22: word address; only bits `[MEM_AW-1:0]` are used, and upper bits alias.
- `az_be_n` in 2: active-low byte enables; bit 0 selects `[7:0]`, bit 1 selects `[15:8]`.
- `az_cs` in 1: chip select; requests are ignored when low.
- `az_data` in 16: write data.
- `az_rd_n` in 1: active-low read request.
- `az_wr_n` in 1: active-low write request.
- `za_data` out 16: read data, meaningful only when `za_valid` is high.
- `za_valid` out 1: one-cycle pulse per accepted read.
- `za_waitrequest` out 1: when high, the current request is not accepted and the initiator holds it.

## Operation
- Reset values:
  - `za_waitrequest` = 1.
  - `za_valid` = 0.
  - `za_data` = 0.
  - Sweep counter = 0, refresh counter = 0, read pipeline empty.
- States:
  - CLEAR: after `reset_n` deasserts, write 0 to each address 0..2^MEM_AW−1, one per cycle. `za_waitrequest` is held at 1. Go to RUN after the last address is written.
  - RUN: `za_waitrequest` = 0 except during a refresh stall. Requests are serviced.
  - STALL (macro only): `za_waitrequest` = 1 for `REFRESH_CYCLES` cycles, then return to RUN.
- Accept condition: `az_cs` & (!`az_rd_n` | !`az_wr_n`) & !`za_waitrequest`, evaluated at the rising edge.
- Write accept: the addressed word is updated at that edge, only the bytes whose `az_be_n` bit is 0. If `az_be_n` = 2'b11 the write is accepted but changes nothing.
- Read accept: the addressed word is captured into the latency pipeline. Back-to-back reads are accepted every cycle, and at most `READ_LATENCY` reads are in flight.
- Read and write both low in the same cycle: only the write is performed, and no `za_valid` is produced for that cycle.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data.
- Requests with `az_cs` = 0 have no effect.
- Reads already in flight complete normally through a STALL; `za_valid` is unaffected by `za_waitrequest`.
- `reset_n` asserted mid-operation:
  - In-flight reads are discarded, and no `za_valid` appears after reset.
  - Memory is re-zeroed by a new CLEAR.

## Timing
- Read accepted in cycle c (at its closing edge): `za_valid` = 1 and `za_data` = the word in cycle c + `READ_LATENCY`, for exactly one cycle.
- `za_data` holds its last value while `za_valid` is low.
- Write: zero latency. No response is generated.
- CLEAR lasts exactly 2^MEM_AW cycles. The first accept can occur in cycle 2^MEM_AW after reset release, counting the first post-reset cycle as 0.
- Refresh (macro only):
  - The refresh counter starts at 0 on entering RUN and counts only in RUN.
  - On reaching `REFRESH_PERIOD`−1 it enters STALL and resets to 0.
- `za_waitrequest` is a registered output and is never derived combinationally from `az_*`.

## Configuration
- `RAM_RESP_REFRESH_STALL_EN` defined: periodic STALL is compiled in, giving SDRAM-like refresh back-pressure.
- Not defined: STALL logic and the refresh counter are absent. After CLEAR, `za_waitrequest` stays 0 until the next reset.

## Test plan
- Reset release with `MEM_AW`=12: `za_waitrequest` is high for exactly 4096 cycles, then falls. A read of 0x3FF then returns 0x0000 with `za_valid` 2 cycles after accept.
- Write 0xBEEF to 0x010, then read 0x010 in the next cycle: `za_data`=0xBEEF with `za_valid` at accept+2. A read of 0x1010 (alias) also returns 0xBEEF.
- Write 0xFFFF to 0x020, then write 0x1234 with `az_be_n`=2'b01: a read of 0x020 returns 0x12FF.
- Reads of 0x000..0x007 in 8 consecutive cycles (memory preloaded with 0xA000+addr): `za_valid` is high for 8 consecutive cycles with data 0xA000..0xA007 in order.
- Read 0x005, then assert `reset_n`=0 one cycle later: no `za_valid` pulse, and `za_waitrequest`=1 immediately.
- With `RAM_RESP_REFRESH_STALL_EN`, `REFRESH_PERIOD`=16, `REFRESH_CYCLES`=4: after CLEAR, `za_waitrequest` pulses high for 4 cycles every 16 cycles. A read held through a stall is accepted once, on the first cycle after the stall, with one `za_valid`.
